xdbladd_unit: RTL
=================

// Module: xdbladd_unit
// PURPOSE
//  Montgomery-curve ladder step responder: from P, Q, x(P-Q) and curve constants (A24p:C24), computes R=2P and S=P+Q.
//  Serves the scalar-ladder controller over the rst_u/done_u handshake.
//  Owns a 20-step microprogram that drives the shared modular multiplier/adder port (mul_a/mul_b/mul_op/mul_rst/mul_done/mul_res).
// PARAMETERS
//  N        512  field element width (bits); all operands Montgomery-form, reduced mod p
//  NSTEPS   20   microprogram length (fixed; from package, not overridable)
// PORTS
//  clk       in   1  clock
//  rst       in   1  reset: synchronous, active-high; clock clk
//  rst_u     in   1  level: 1 = hold idle/abort and capture inputs, 0 = run
//  done_u    out  1  1 = rx/rz/sx/sz valid; held until rst_u=1
//  px,pz     in   N  point P (doubled); stable while rst_u=0
//  qx,qz     in   N  point Q
//  pqx,pqz   in   N  difference P-Q
//  ax,az     in   N  A24p=(A+2C), C24=4C
//  rx,rz     out  N  R=2P
//  sx,sz     out  N  S=P+Q
//  mul_a     out  N  operand a to shared arithmetic unit
//  mul_b     out  N  operand b
//  mul_op    out  2  00 a*b*R^-1 mod p, 01 a+b mod p, 10 a-b mod p, 11 reserved (never driven)
//  mul_rst   out  1  1 = clear/arm unit, falling edge starts op
//  mul_done  in   1  result valid (only meaningful while mul_rst=0)
//  mul_res   in   N  result
// BEHAVIOUR
//  Reset (rst=1): state IDLE, step=0, done_u=0, mul_rst=1, mul_op=00, mul_a/mul_b=0.
//    All working regs (t0,t1,t2) and rx,rz,sx,sz = 0.
//  rst has priority over rst_u.
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//   IDLE: mul_rst=1. Every cycle rst_u=1, latch px..az into input regs.
//         On the first cycle with rst_u=0 -> ISSUE.
//   ISSUE (1 cycle): drive mul_a/mul_b/mul_op from ROM[step]; mul_rst=1 -> WAIT.
//   WAIT: mul_rst=0, operands held. On mul_done=1, write mul_res to ROM[step].dst.
//         If step==19 -> DONE; else step++ -> ISSUE.
//   DONE: done_u=1, outputs frozen, mul_rst=1. On rst_u=1 -> IDLE, done_u=0 next cycle.
//  rst_u=1 in ISSUE/WAIT (abort): no register write that cycle; -> IDLE, step=0, mul_rst=1.
//  A mul_done coinciding with abort is discarded.
//  mul_done is ignored outside WAIT. The unit clears mul_done whenever mul_rst=1, so a stale done cannot be seen.
//  Latency: with unit latency L (WAIT cycles incl. done cycle), done_u=1 in cycle 1+20*(1+L).
//    Cycle 0 = first cycle sampling rst_u=0.
//  Microprogram (dst = srcA op srcB):
//    1 t0=px+pz    2 t1=px-pz    3 rx=t0*t0    4 t2=qx-qz
//    5 sx=qx+qz    6 t0=t0*t2    7 rz=t1*t1    8 t1=t1*sx
//    9 t2=rx-rz    10 rz=az*rz   11 rx=rx*rz   12 sx=ax*t2
//    13 sz=t0-t1   14 rz=rz+sx   15 sx=t0+t1   16 rz=rz*t2
//    17 sz=sz*sz   18 sx=sx*sx   19 sz=pqx*sz  20 sx=pqz*sx
//  Op counts: 12 mul, 4 add, 4 sub. Strictly in order, one op in flight.
//  Reads return the value written by the previous step.
//  rx,rz,sx,sz are working regs. They change during the run; valid only when done_u=1.
// STRUCTURE
//  Package xdbladd_pkg:
//    - op enum (OP_MUL/OP_ADD/OP_SUB)
//    - 4-bit register-index enum (PX,PZ,QX,QZ,PQX,PQZ,AX,AZ,T0,T1,T2,RX,RZ,SX,SZ)
//    - NSTEPS=20; step record {op, srcA, srcB, dst}
//  Sub-module xdbladd_ucode_rom:
//    - combinational, step[4:0] -> record
//    - out-of-range step returns {OP_MUL, T0, T0, T0}, never used
//  Top: FSM, step counter, 15-entry operand mux, dst write decode.
// TESTING
//  Bench multiplier: behavioural Montgomery unit mod CSIDH-512 p, L=3. All checks against a golden Python ladder step.
//  1. P=(fp1,0) (infinity), Q=PQ=random valid point
//     -> rz==0; sx*qz==sz*qx mod p; done_u at cycle 81.
//  2. Random P,Q,PQ, A=0 (ax=2*fp1, az=4*fp1)
//     -> rx/rz/sx/sz bit-exact to golden; exactly 12 OP_MUL, 4 OP_ADD, 4 OP_SUB issued, in ROM order.
//  3. rst_u=1 mid-run at step 7 WAIT with mul_done=1 same cycle
//     -> no write; IDLE; rst_u=0 restart gives golden result; done_u never glitches high.
//  4. Hold rst_u=0 in DONE for 50 cycles
//     -> outputs/done_u stable, mul_rst=1 throughout.
//     Then rst_u=1 one cycle -> done_u=0 next cycle.
//  5. rst=1 during step 15 -> all outputs 0, done_u=0, mul_rst=1 next cycle; new run from IDLE bit-exact.
//  6. 1000 back-to-back ladder steps driven like the ladder controller
//     (rst_u released 1 cycle after inputs update, variable L=1..8) -> all match golden.

Source files
------------

// File: rtl/xdbladd_pkg.sv
// rtl/xdbladd_pkg.sv - shared types for the Montgomery ladder step unit
// Contents: op_e (arithmetic op code on mul_op), reg_e (operand/destination
// register index), ustep_t (one microprogram step), state_e (sequencer FSM),
// NSTEPS (microprogram length) and mk_step (ROM entry builder).
package xdbladd_pkg;

    localparam int NSTEPS = 20;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } op_e;

    typedef enum logic [3:0] {
        PX, PZ, QX, QZ, PQX, PQZ, AX, AZ,
        T0, T1, T2, RX, RZ, SX, SZ
    } reg_e;

    typedef struct packed {
        op_e  op;
        reg_e src_a;
        reg_e src_b;
        reg_e dst;
    } ustep_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    function automatic ustep_t mk_step(op_e o, reg_e a, reg_e b, reg_e d);
        return '{op: o, src_a: a, src_b: b, dst: d};
    endfunction

endpackage

// File: rtl/xdbladd_if.sv
// rtl/xdbladd_if.sv - port to the shared modular multiplier/adder unit
// master (sequencer): drives mul_a, mul_b, mul_op, mul_rst; reads mul_done, mul_res.
// slave (arithmetic unit): the reverse.
// mul_rst=1 clears/arms the unit, its falling edge starts the operation.
interface xdbladd_if #(
    parameter int N = 512
);
    logic [N-1:0] mul_a;
    logic [N-1:0] mul_b;
    logic [1:0]   mul_op;
    logic         mul_rst;
    logic         mul_done;
    logic [N-1:0] mul_res;

    modport master (output mul_a, mul_b, mul_op, mul_rst, input mul_done, mul_res);
    modport slave  (input mul_a, mul_b, mul_op, mul_rst, output mul_done, mul_res);
endinterface

// File: rtl/xdbladd_ucode_rom.sv
// rtl/xdbladd_ucode_rom.sv - 20-step xDBLADD microprogram
// Ports: step (5-bit step index) in, rec (op, src_a, src_b, dst) out.
// Purely combinational; indices past the last step return a harmless MUL T0,T0->T0.
module xdbladd_ucode_rom
    import xdbladd_pkg::*;
(
    input  logic [4:0] step,
    output ustep_t     rec
);

    always_comb begin
        rec = mk_step(OP_MUL, T0, T0, T0);
        case (step)
            5'd0:  rec = mk_step(OP_ADD, PX,  PZ, T0);
            5'd1:  rec = mk_step(OP_SUB, PX,  PZ, T1);
            5'd2:  rec = mk_step(OP_MUL, T0,  T0, RX);
            5'd3:  rec = mk_step(OP_SUB, QX,  QZ, T2);
            5'd4:  rec = mk_step(OP_ADD, QX,  QZ, SX);
            5'd5:  rec = mk_step(OP_MUL, T0,  T2, T0);
            5'd6:  rec = mk_step(OP_MUL, T1,  T1, RZ);
            5'd7:  rec = mk_step(OP_MUL, T1,  SX, T1);
            5'd8:  rec = mk_step(OP_SUB, RX,  RZ, T2);
            5'd9:  rec = mk_step(OP_MUL, AZ,  RZ, RZ);
            5'd10: rec = mk_step(OP_MUL, RX,  RZ, RX);
            5'd11: rec = mk_step(OP_MUL, AX,  T2, SX);
            5'd12: rec = mk_step(OP_SUB, T0,  T1, SZ);
            5'd13: rec = mk_step(OP_ADD, RZ,  SX, RZ);
            5'd14: rec = mk_step(OP_ADD, T0,  T1, SX);
            5'd15: rec = mk_step(OP_MUL, RZ,  T2, RZ);
            5'd16: rec = mk_step(OP_MUL, SZ,  SZ, SZ);
            5'd17: rec = mk_step(OP_MUL, SX,  SX, SX);
            5'd18: rec = mk_step(OP_MUL, PQX, SZ, SZ);
            5'd19: rec = mk_step(OP_MUL, PQZ, SX, SX);
            default: ;
        endcase
    end

endmodule

// File: rtl/xdbladd_unit.sv
// rtl/xdbladd_unit.sv - Montgomery ladder step: R=2P, S=P+Q via a shared arithmetic unit
// Ports: clk, rst (sync, active-high); rst_u (1 = idle/abort + capture inputs),
// done_u (results valid); px,pz,qx,qz,pqx,pqz,ax,az operand inputs;
// rx,rz,sx,sz results (working registers, valid only while done_u=1);
// mul (xdbladd_if.master) to the shared multiplier/adder.
module xdbladd_unit
    import xdbladd_pkg::*;
#(
    parameter int N = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rst_u,
    output logic         done_u,
    input  logic [N-1:0] px,
    input  logic [N-1:0] pz,
    input  logic [N-1:0] qx,
    input  logic [N-1:0] qz,
    input  logic [N-1:0] pqx,
    input  logic [N-1:0] pqz,
    input  logic [N-1:0] ax,
    input  logic [N-1:0] az,
    output logic [N-1:0] rx,
    output logic [N-1:0] rz,
    output logic [N-1:0] sx,
    output logic [N-1:0] sz,
    xdbladd_if.master    mul
);

    state_e       state, state_nxt;
    logic [4:0]   step, step_nxt;
    logic         wr_en;
    logic         active;
    ustep_t       rec;
    logic [N-1:0] in_px, in_pz, in_qx, in_qz, in_pqx, in_pqz, in_ax, in_az;
    logic [N-1:0] t0, t1, t2;
    logic [N-1:0] rf [16];

    xdbladd_ucode_rom u_rom (
        .step (step),
        .rec  (rec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // rst_u wins over mul_done in ISSUE/WAIT: an abort never commits a result.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        wr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                step_nxt = '0;
                if (!rst_u) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (rst_u) begin
                    state_nxt = ST_IDLE;
                    step_nxt  = '0;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rst_u) begin
                    state_nxt = ST_IDLE;
                    step_nxt  = '0;
                end else if (mul.mul_done) begin
                    wr_en = 1'b1;
                    if (step == 5'(NSTEPS - 1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        step_nxt  = step + 5'd1;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                if (rst_u) begin
                    state_nxt = ST_IDLE;
                    step_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                step_nxt  = '0;
            end
        endcase
    end

    // Operand file indexed directly by reg_e; slot 15 is unused.
    always_comb begin
        rf[0]  = in_px;  rf[1]  = in_pz;  rf[2]  = in_qx;  rf[3]  = in_qz;
        rf[4]  = in_pqx; rf[5]  = in_pqz; rf[6]  = in_ax;  rf[7]  = in_az;
        rf[8]  = t0;     rf[9]  = t1;     rf[10] = t2;     rf[11] = rx;
        rf[12] = rz;     rf[13] = sx;     rf[14] = sz;     rf[15] = '0;
    end

    assign active       = (state == ST_ISSUE) || (state == ST_WAIT);
    assign mul.mul_a    = active ? rf[rec.src_a] : '0;
    assign mul.mul_b    = active ? rf[rec.src_b] : '0;
    assign mul.mul_op   = active ? rec.op : OP_MUL;
    assign mul.mul_rst  = (state != ST_WAIT);
    assign done_u       = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_px <= '0; in_pz <= '0; in_qx <= '0; in_qz <= '0;
            in_pqx <= '0; in_pqz <= '0; in_ax <= '0; in_az <= '0;
            t0 <= '0; t1 <= '0; t2 <= '0;
            rx <= '0; rz <= '0; sx <= '0; sz <= '0;
        end else begin
            if (rst_u) begin
                in_px  <= px;  in_pz  <= pz;  in_qx <= qx; in_qz <= qz;
                in_pqx <= pqx; in_pqz <= pqz; in_ax <= ax; in_az <= az;
            end
            if (wr_en) begin
                case (rec.dst)
                    T0: t0 <= mul.mul_res;
                    T1: t1 <= mul.mul_res;
                    T2: t2 <= mul.mul_res;
                    RX: rx <= mul.mul_res;
                    RZ: rz <= mul.mul_res;
                    SX: sx <= mul.mul_res;
                    SZ: sz <= mul.mul_res;
                    default: ;
                endcase
            end
        end
    end

endmodule
